// File: rtl/xalu_seq.sv
// ----------------------------------------------------------------------------
// xalu_seq -- registered, handshaked ALU with status flags.
//
// Captures a request on in_valid && in_ready, computes one of ADD, AND, OR,
// XOR, PASSA, PASSB, SHR, SHL, SUB (and optionally an unsigned shift-add MUL),
// and presents a registered result, high product half and flag word until the
// consumer takes it with out_ready.
//
// Optional feature macro: XALU_MUL_EN
//   defined   : op 9 is a WIDTH-cycle shift-add multiplier ({hi, result}).
//   undefined : op 9 is reserved (single cycle, result 0, illegal=1).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   a, b                 WIDTH-bit operands        (captured on acceptance)
//   op                   4-bit function code       (captured on acceptance)
//   cin                  carry / shift-fill input  (captured on acceptance)
//   com                  complement-result mode    (captured on acceptance)
//   in_valid / in_ready  request handshake; in_ready high only in IDLE
//   out_valid/out_ready  result handshake; outputs held while out_ready=0
//   result               registered result (low product half for MUL)
//   hi                   registered high product half, 0 for non-MUL ops
//   flags                {illegal, ovf, equ, ones, zero, carry}
// ----------------------------------------------------------------------------
module xalu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             com,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [5:0]       flags
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_PASSA = 4'd4;
  localparam logic [3:0] OP_PASSB = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SUB   = 4'd8;
`ifdef XALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam int         CNT_W    = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef XALU_MUL_EN
    S_MUL,
`endif
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_op;
  logic             r_cin, r_com;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result, r_hi;
  logic [5:0]       r_flags;

`ifdef XALU_MUL_EN
  // Running product: r_acc is the high half, r_mq starts as the multiplier
  // and fills with product bits from the top as it shifts right.
  logic [WIDTH-1:0] r_acc, r_mq;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_mul_sum;

  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_a} : '0);
`endif

  // Shared adder: SUB reuses ADD with the B operand inverted.
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;

  assign w_addend = (r_op == OP_SUB) ? ~r_b : r_b;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, r_cin};

  logic [WIDTH-1:0] w_res_raw, w_res, w_hi;
  logic             w_carry, w_ovf, w_illegal;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_res_raw = '0;
    w_hi      = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_res_raw = w_sum[WIDTH-1:0];
        w_carry   = w_sum[WIDTH];
        w_ovf     = (r_a[WIDTH-1] == w_addend[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:   w_res_raw = r_a & r_b;
      OP_OR:    w_res_raw = r_a | r_b;
      OP_XOR:   w_res_raw = r_a ^ r_b;
      OP_PASSA: w_res_raw = r_a;
      OP_PASSB: w_res_raw = r_b;
      OP_SHR: begin
        w_res_raw = {r_cin, r_a[WIDTH-1:1]};
        w_carry   = r_a[0];
      end
      OP_SHL: begin
        w_res_raw = {r_a[WIDTH-2:0], r_cin};
        w_carry   = r_a[WIDTH-1];
      end
`ifdef XALU_MUL_EN
      OP_MUL: begin
        w_res_raw = r_mq;
        w_hi      = r_acc;
        w_carry   = |r_acc;
      end
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

  // Complement applies to result only; zero/ones see the complemented value.
  assign w_res = r_com ? ~w_res_raw : w_res_raw;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cin       <= 1'b0;
      r_com       <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_hi        <= '0;
      r_flags     <= '0;
`ifdef XALU_MUL_EN
      r_acc       <= '0;
      r_mq        <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cin   <= cin;
            r_com   <= com;
            r_state <= S_DONE;
`ifdef XALU_MUL_EN
            if (op == OP_MUL) begin
              r_acc   <= '0;
              r_mq    <= b;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_state <= S_MUL;
            end
`endif
          end
        end
`ifdef XALU_MUL_EN
        S_MUL: begin
          // {acc, mq} <= {acc + (mq[0] ? a : 0), mq} >> 1
          r_acc <= w_mul_sum[WIDTH:1];
          r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
          if (r_cnt == '0) r_state <= S_DONE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
`endif
        S_DONE: begin
          // First DONE cycle registers the outputs; afterwards they are held
          // until the consumer accepts them.
          if (!r_out_valid) begin
            r_result    <= w_res;
            r_hi        <= w_hi;
            r_flags     <= {w_illegal, w_ovf, (r_a == r_b), &w_res, ~|w_res, w_carry};
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign hi        = r_hi;
  assign flags     = r_flags;

endmodule

// File: tb/tb_xalu_seq.sv
// ----------------------------------------------------------------------------
// tb_xalu_seq -- self-checking bench for xalu_seq (WIDTH = 8).
//
// A transaction-level model predicts, per clock, in_ready, out_valid and the
// held result/hi/flags from the arithmetic definition of each op and the
// documented latencies; a negedge process compares the DUT against it every
// cycle. Directed vectors additionally pin both model and DUT to
// hand-computed literals. Works with or without XALU_MUL_EN.
// ----------------------------------------------------------------------------
module tb_xalu_seq;

  localparam int     W    = 8;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   op = '0;
  logic         cin = 1'b0, com = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid;
  logic [W-1:0] result, hi;
  logic [5:0]   flags;

  xalu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .cin(cin), .com(com),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] res;
    logic [5:0]   flags;
  } out_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint sval(input longint x);
    return x[W-1] ? x - (longint'(1) << W) : x;
  endfunction

  function automatic out_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                 input logic [3:0] op_i, input logic cin_i, input logic com_i);
    longint av, bv, ci, r, h, s, add;
    logic   c, v, ill;
    out_t   o;
    av = longint'(a_i); bv = longint'(b_i); ci = longint'(cin_i);
    r = 0; h = 0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op_i)
      4'd0, 4'd8: begin
        add = (op_i == 4'd8) ? (~bv & MASK) : bv;
        s   = av + add + ci;
        r   = s & MASK;
        c   = (s > MASK);
        s   = sval(av) + sval(add) + ci;
        v   = (s > (MASK >> 1)) || (s < -(MASK >> 1) - 1);
      end
      4'd1: r = av & bv;
      4'd2: r = av | bv;
      4'd3: r = av ^ bv;
      4'd4: r = av;
      4'd5: r = bv;
      4'd6: begin r = (av >> 1) | (ci << (W - 1)); c = av[0];   end
      4'd7: begin r = ((av << 1) | ci) & MASK;     c = av[W-1]; end
`ifdef XALU_MUL_EN
      4'd9: begin s = av * bv; r = s & MASK; h = s >> W; c = (h != 0); end
`endif
      default: ill = 1'b1;
    endcase
    if (com_i) r = ~r & MASK;
    o.hi    = h[W-1:0];
    o.res   = r[W-1:0];
    o.flags = {ill, v, (a_i == b_i), (r == MASK), (r == 0), c};
    return o;
  endfunction

  // Edges from acceptance until out_valid is high.
  function automatic int lat_of(input logic [3:0] o);
`ifdef XALU_MUL_EN
    if (o == 4'd9) return W + 1;
`endif
    return 1;
  endfunction

  // Cycle-level prediction of the handshake and held outputs.
  int   e = 0;
  int   m_vedge = 0;
  bit   m_busy = 1'b0;
  out_t m_out = '0, m_exp = '0;
  bit   exp_valid = 1'b0, exp_in_ready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_out = '0; exp_valid = 1'b0; exp_in_ready = 1'b1;
    end else begin
      e++;
      if (m_busy) begin
        if (e > m_vedge && out_ready) m_busy = 1'b0;
      end else if (in_valid) begin
        m_busy  = 1'b1;
        m_vedge = e + lat_of(op);
        m_exp   = model(a, b, op, cin, com);
      end
      if (m_busy && e == m_vedge) m_out = m_exp;
      exp_valid    = m_busy && (e >= m_vedge);
      exp_in_ready = !m_busy;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_in_ready",  in_ready,  exp_in_ready);
      check("cyc_out_valid", out_valid, exp_valid);
      check("cyc_result",    result,    m_out.res);
      check("cyc_hi",        hi,        m_out.hi);
      check("cyc_flags",     flags,     m_out.flags);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic start_req(input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic [3:0] oi, input logic ci, input logic mi);
    a = ai; b = bi; op = oi; cin = ci; com = mi; in_valid = 1'b1;
  endtask

  // Returns just after the accepting edge; scrambles inputs so an op in
  // flight must not depend on them.
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 4'($urandom);
        cin = 1'($urandom); com = 1'($urandom);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Counts negedges from the accepting edge to the first out_valid=1.
  task automatic wait_valid(input int lat);
    int n = 0;
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("valid_timeout", 0, 1);
    else     check("latency", n, lat + 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_out(input string name, input out_t x);
    check({name, "_res"},   result, x.res);
    check({name, "_hi"},    hi,     x.hi);
    check({name, "_flags"}, flags,  x.flags);
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic [3:0] oi, input logic ci, input logic mi, input out_t lit);
    check({name, "_model"}, model(ai, bi, oi, ci, mi), lit);
    start_req(ai, bi, oi, ci, mi);
    wait_accept();
    wait_valid(lat_of(oi));
    check_out(name, lit);
    consume();
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         cin, com;
  } vec_t;

  vec_t vecs[12] = '{
    '{8'h0F, 8'h3C, 4'd1,  1'b0, 1'b0},  // AND
    '{8'h0F, 8'h3C, 4'd2,  1'b0, 1'b0},  // OR
    '{8'h77, 8'h77, 4'd3,  1'b0, 1'b0},  // XOR equal -> zero, equ
    '{8'h00, 8'h11, 4'd5,  1'b0, 1'b1},  // PASSB complemented
    '{8'h01, 8'h00, 4'd6,  1'b1, 1'b0},  // SHR fill + carry
    '{8'h7F, 8'h01, 4'd0,  1'b0, 1'b0},  // ADD signed overflow
    '{8'hFF, 8'h01, 4'd0,  1'b0, 1'b1},  // ADD wrap, complemented
    '{8'h10, 8'h20, 4'd8,  1'b1, 1'b0},  // SUB borrow
    '{8'h40, 8'h00, 4'd7,  1'b0, 1'b0},  // SHL
    '{8'h12, 8'h34, 4'd10, 1'b0, 1'b1},  // reserved, complemented
    '{8'hFF, 8'hFF, 4'd9,  1'b0, 1'b0},  // MUL max (reserved without macro)
    '{8'h80, 8'h80, 4'd0,  1'b0, 1'b0}   // ADD -128 + -128
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result",    result,    0);
    check("rst_hi",        hi,        0);
    check("rst_flags",     flags,     0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed vectors: flags = {illegal, ovf, equ, ones, zero, carry}
    run_lit("add_f0_20",  8'hF0, 8'h20, 4'd0, 1'b0, 1'b0, out_t'({8'h00, 8'h10, 6'b000001}));
    run_lit("sub_05_05",  8'h05, 8'h05, 4'd8, 1'b1, 1'b0, out_t'({8'h00, 8'h00, 6'b001011}));
    run_lit("sub_7f_ff",  8'h7F, 8'hFF, 4'd8, 1'b1, 1'b0, out_t'({8'h00, 8'h80, 6'b010000}));
`ifdef XALU_MUL_EN
    run_lit("mul_c8_03",  8'hC8, 8'h03, 4'd9, 1'b0, 1'b0, out_t'({8'h02, 8'h58, 6'b000001}));
`else
    run_lit("mul_c8_03",  8'hC8, 8'h03, 4'd9, 1'b0, 1'b0, out_t'({8'h00, 8'h00, 6'b100010}));
`endif
    run_lit("passa_com",  8'h00, 8'h55, 4'd4, 1'b0, 1'b1, out_t'({8'h00, 8'hFF, 6'b000100}));
    run_lit("shl_81",     8'h81, 8'h00, 4'd7, 1'b1, 1'b0, out_t'({8'h00, 8'h03, 6'b000001}));
    run_lit("rsv_15",     8'h12, 8'h34, 4'd15, 1'b0, 1'b0, out_t'({8'h00, 8'h00, 6'b100010}));

    // Model-checked vectors, back to back
    foreach (vecs[i]) begin
      start_req(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, vecs[i].com);
      wait_accept();
      wait_valid(lat_of(vecs[i].op));
      consume();
    end

    // Held DONE with a competing request
    start_req(8'hA5, 8'h5A, 4'd3, 1'b0, 1'b0);
    wait_accept();
    wait_valid(1);
    start_req(8'h12, 8'h34, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_in_ready",  in_ready,  0);
      check("hold_out_valid", out_valid, 1);
      check("hold_result",    result,    8'hFF);
      check("hold_flags",     flags,     6'b000100);
    end
    consume();
    @(negedge clk);
    check("hold_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(1);
    check_out("hold_next", out_t'({8'h00, 8'h47, 6'b000000}));
    consume();

    // Asynchronous reset while an op is in flight
`ifdef XALU_MUL_EN
    start_req(8'hC8, 8'h03, 4'd9, 1'b0, 1'b0);
    wait_accept();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
`else
    start_req(8'h3C, 8'h00, 4'd4, 1'b0, 1'b0);
    wait_accept();
    wait_valid(1);
    #2 rst_n = 1'b0;
`endif
    #1;
    check("arst_result",    result,    0);
    check("arst_hi",        hi,        0);
    check("arst_flags",     flags,     0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready",  in_ready,  1);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
      check("post_rst_ready",    in_ready,  1);
    end
    @(posedge clk); #1;
    run_lit("post_rst_add", 8'h01, 8'h01, 4'd0, 1'b0, 1'b0, out_t'({8'h00, 8'h02, 6'b001000}));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
